// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: master FSM states and xRESP encodings.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator, one transaction in flight; all outputs registered, 4-cycle best-case turnaround.
// Every valid is held until its ready; a pending rsp_valid blocks new commands (cmd_ready low).
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int axi_addr_width = 32,
  parameter int axi_data_width = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_we,
  input  logic [axi_addr_width-1:0]     cmd_addr,
  input  logic [axi_data_width-1:0]     cmd_wdata,
  input  logic [axi_data_width/8-1:0]   cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [axi_data_width-1:0]     rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_we,
  output logic [axi_addr_width-1:0]     axi_awaddr,
  output logic                          axi_awvalid,
  input  logic                          axi_awready,
  output logic [axi_data_width-1:0]     axi_wdata,
  output logic [axi_data_width/8-1:0]   axi_wstrb,
  output logic                          axi_wvalid,
  input  logic                          axi_wready,
  input  logic [1:0]                    axi_bresp,
  input  logic                          axi_bvalid,
  output logic                          axi_bready,
  output logic [axi_addr_width-1:0]     axi_araddr,
  output logic                          axi_arvalid,
  input  logic                          axi_arready,
  input  logic [axi_data_width-1:0]     axi_rdata,
  input  logic [1:0]                    axi_rresp,
  input  logic                          axi_rvalid,
  output logic                          axi_rready
);

  state_t state, state_next;
  logic   aw_done, w_done, aw_done_next, w_done_next;
  logic   cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

  // Handshakes use the registered valid/ready, so an early ready never counts.
  assign cmd_hs = cmd_valid & cmd_ready;
  assign aw_hs  = axi_awvalid & axi_awready;
  assign w_hs   = axi_wvalid & axi_wready;
  assign b_hs   = axi_bvalid & axi_bready;
  assign ar_hs  = axi_arvalid & axi_arready;
  assign r_hs   = axi_rvalid & axi_rready;
  assign rsp_hs = rsp_valid & rsp_ready;

  always_comb begin
    state_next   = state;
    aw_done_next = aw_done;
    w_done_next  = w_done;
    case (state)
      IDLE: begin
        aw_done_next = 1'b0;
        w_done_next  = 1'b0;
        if (cmd_hs) state_next = cmd_we ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        aw_done_next = aw_done | aw_hs;
        w_done_next  = w_done | w_hs;
        if (aw_done_next && w_done_next) state_next = WR_RESP;
      end
      WR_RESP: if (b_hs)   state_next = RESP;
      RD_REQ:  if (ar_hs)  state_next = RD_DATA;
      RD_DATA: if (r_hs)   state_next = RESP;
      RESP:    if (rsp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_next;
      aw_done <= aw_done_next;
      w_done  <= w_done_next;
    end
  end

  // Control outputs are decoded from the next state so they land registered in the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready   <= 1'b1;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      rsp_valid   <= 1'b0;
    end else begin
      cmd_ready   <= (state_next == IDLE);
      axi_awvalid <= (state_next == WR_REQ) && !aw_done_next;
      axi_wvalid  <= (state_next == WR_REQ) && !w_done_next;
      axi_bready  <= (state_next == WR_RESP);
      axi_arvalid <= (state_next == RD_REQ);
      axi_rready  <= (state_next == RD_DATA);
      rsp_valid   <= (state_next == RESP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_awaddr <= '0;
      axi_wdata  <= '0;
      axi_wstrb  <= '0;
      axi_araddr <= '0;
      rsp_rdata  <= '0;
      rsp_resp   <= OKAY;
      rsp_we     <= 1'b0;
    end else begin
      if (cmd_hs) begin
        if (cmd_we) begin
          axi_awaddr <= cmd_addr;
          axi_wdata  <= cmd_wdata;
          axi_wstrb  <= cmd_wstrb;
        end else begin
          axi_araddr <= cmd_addr;
        end
      end
      if (b_hs) begin
        rsp_rdata <= '0;
        rsp_resp  <= axi_bresp;
        rsp_we    <= 1'b1;
      end
      if (r_hs) begin
        rsp_rdata <= axi_rdata;
        rsp_resp  <= axi_rresp;
        rsp_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: the bench plays the AXI responder cycle by cycle.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [3:0]  axi_wstrb;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [1:0]  axi_bresp, axi_rresp;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic        axi_rvalid, axi_rready;

  int checks = 0;
  int failures = 0;

  axi_lite_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_we(rsp_we),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = strb;
    check_eq("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("rsp_valid_after_consume", {31'd0, rsp_valid}, 32'd0);
    check_eq("cmd_ready_after_consume", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00;
    #3;
    check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rst_valids", {26'd0, axi_awvalid, axi_wvalid, axi_arvalid,
                            axi_bready, axi_rready, rsp_valid}, 32'd0);
    check_eq("rst_payload", axi_awaddr | axi_wdata | axi_araddr | rsp_rdata
                            | {28'd0, axi_wstrb} | {30'd0, rsp_resp} | {31'd0, rsp_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Write with an always-ready responder.
    axi_awready = 1'b1; axi_wready = 1'b1;
    send_cmd(1'b1, 32'h10, 32'hA5A5_1234, 4'hF);
    check_eq("wr1_c1_valids", {30'd0, axi_awvalid, axi_wvalid}, 32'd3);
    check_eq("wr1_awaddr", axi_awaddr, 32'h10);
    check_eq("wr1_wdata", axi_wdata, 32'hA5A5_1234);
    check_eq("wr1_wstrb", {28'd0, axi_wstrb}, 32'hF);
    check_eq("wr1_c1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    check_eq("wr1_c2_valids", {30'd0, axi_awvalid, axi_wvalid}, 32'd0);
    check_eq("wr1_c2_bready", {31'd0, axi_bready}, 32'd1);
    axi_bvalid = 1'b1; axi_bresp = 2'b00;
    tick();
    axi_bvalid = 1'b0;
    check_eq("wr1_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("wr1_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    check_eq("wr1_rsp_we", {31'd0, rsp_we}, 32'd1);
    check_eq("wr1_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("wr1_c3_bready", {31'd0, axi_bready}, 32'd0);
    consume_rsp();

    // Read: arready after 3 waiting cycles, rvalid after 2.
    axi_awready = 1'b0; axi_wready = 1'b0;
    send_cmd(1'b0, 32'h44, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      check_eq("rd_arvalid_held", {31'd0, axi_arvalid}, 32'd1);
      check_eq("rd_araddr_stable", axi_araddr, 32'h44);
      if (i == 3) axi_arready = 1'b1;
      tick();
    end
    axi_arready = 1'b0;
    check_eq("rd_arvalid_dropped", {31'd0, axi_arvalid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      check_eq("rd_rready_wait", {31'd0, axi_rready}, 32'd1);
      check_eq("rd_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    axi_rvalid = 1'b1; axi_rdata = 32'hDEAD_BEEF; axi_rresp = 2'b00;
    tick();
    axi_rvalid = 1'b0;
    check_eq("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check_eq("rd_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    check_eq("rd_rsp_we", {31'd0, rsp_we}, 32'd0);
    check_eq("rd_rready_dropped", {31'd0, axi_rready}, 32'd0);
    consume_rsp();

    // Skewed write: W completes two cycles before AW, responder answers SLVERR.
    send_cmd(1'b1, 32'h20, 32'h1111_2222, 4'h3);
    check_eq("skew_c1_valids", {30'd0, axi_awvalid, axi_wvalid}, 32'd3);
    axi_wready = 1'b1;
    tick();
    axi_wready = 1'b0;
    check_eq("skew_c2_valids", {30'd0, axi_awvalid, axi_wvalid}, 32'd2);
    check_eq("skew_c2_bready", {31'd0, axi_bready}, 32'd0);
    tick();
    check_eq("skew_c3_valids", {30'd0, axi_awvalid, axi_wvalid}, 32'd2);
    axi_awready = 1'b1;
    tick();
    axi_awready = 1'b0;
    check_eq("skew_c4_valids", {30'd0, axi_awvalid, axi_wvalid}, 32'd0);
    check_eq("skew_c4_bready", {31'd0, axi_bready}, 32'd1);
    axi_bvalid = 1'b1; axi_bresp = 2'b10;
    tick();
    check_eq("skew_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("skew_rsp_slverr", {30'd0, rsp_resp}, 32'd2);
    check_eq("skew_bready_once", {31'd0, axi_bready}, 32'd0);
    axi_bresp = 2'b00;
    tick();
    axi_bvalid = 1'b0;
    check_eq("skew_second_b_ignored", {30'd0, rsp_resp}, 32'd2);
    check_eq("skew_bready_still_low", {31'd0, axi_bready}, 32'd0);
    consume_rsp();

    // Read with DECERR, then hold the response under back-pressure.
    axi_arready = 1'b1;
    send_cmd(1'b0, 32'h80, 32'h0, 4'h0);
    tick();
    axi_arready = 1'b0;
    axi_rvalid = 1'b1; axi_rdata = 32'h0BAD_F00D; axi_rresp = 2'b11;
    tick();
    axi_rvalid = 1'b0;
    check_eq("dec_rsp_resp", {30'd0, rsp_resp}, 32'd3);
    check_eq("dec_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hC;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check_eq("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("bp_rsp_payload", rsp_rdata, 32'h0BAD_F00D);
      check_eq("bp_rsp_resp", {30'd0, rsp_resp}, 32'd3);
      check_eq("bp_no_axi_valids", {29'd0, axi_awvalid, axi_wvalid, axi_arvalid}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("bp_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    check_eq("rstmid_awvalid_up", {31'd0, axi_awvalid}, 32'd1);
    check_eq("rstmid_awaddr", axi_awaddr, 32'h30);

    // Asynchronous reset while awvalid is high.
    #2;
    rst = 1'b1;
    #1;
    check_eq("rstmid_valids", {26'd0, axi_awvalid, axi_wvalid, axi_arvalid,
                               axi_bready, axi_rready, rsp_valid}, 32'd0);
    check_eq("rstmid_awaddr_cleared", axi_awaddr, 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("rstmid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    axi_arready = 1'b1;
    send_cmd(1'b0, 32'h50, 32'h0, 4'h0);
    check_eq("post_arvalid", {31'd0, axi_arvalid}, 32'd1);
    check_eq("post_araddr", axi_araddr, 32'h50);
    tick();
    axi_arready = 1'b0;
    axi_rvalid = 1'b1; axi_rdata = 32'h1234_5678; axi_rresp = 2'b00;
    tick();
    axi_rvalid = 1'b0;
    check_eq("post_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("post_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check_eq("post_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    consume_rsp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
